// File: rtl/rapcore_reset_pkg.sv
// Shared types and helpers for the rapcore reset sequencer.
// Holds the 2-bit sequencer state encoding and the domain-index width function.
package rapcore_reset_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  // Wide enough to hold any value 0..n inclusive.
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rapcore_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// Used for the reset-stretch counter and the abort counter.
module rapcore_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rapcore_reset_sequencer.sv
// Power-on/reset sequencer: stretches reset for 2^CNT_WIDTH cycles, then releases
// NUM_DOMAINS active-low resets in order, GAP_CYCLES apart. Any drop of go aborts.
module rapcore_reset_sequencer
  import rapcore_reset_pkg::*;
#(
  parameter int CNT_WIDTH     = 14,
  parameter int NUM_DOMAINS   = 3,
  parameter int GAP_CYCLES    = 16,
  parameter int MON_WIDTH     = 8,
  parameter int RST_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     resetn_in,
  input  logic                     sys_rst_i,
  input  logic                     run_req_i,
  output logic [NUM_DOMAINS-1:0]   domain_resetn_o,
  output logic                     all_released_o,
  output logic [1:0]               state_o,
  output logic [MON_WIDTH-1:0]     mon_o,
  output logic [RST_CNT_WIDTH-1:0] restart_cnt_o
);

  localparam int IDX_W = idx_width(NUM_DOMAINS);
  localparam int GAP_W = idx_width(GAP_CYCLES);

  state_t                 state;
  logic [NUM_DOMAINS-1:0] domain_q;
  logic                   all_released_q;
  logic [IDX_W-1:0]       idx;
  logic [GAP_W-1:0]       gap;
  logic [CNT_WIDTH-1:0]   stretch_cnt;
  logic                   go;
  logic                   abort;

  assign go    = run_req_i & ~sys_rst_i;
  assign abort = ~go & (state != IDLE);

  // Stretch counter only advances in STRETCH; it saturates, so it reads
  // all-ones for the rest of the sequence and drops to 0 whenever go falls.
  rapcore_sat_counter #(.WIDTH(CNT_WIDTH)) u_stretch_cnt (
    .clk   (CLK),
    .rst_n (resetn_in),
    .clr   (~go | (state == IDLE)),
    .en    (state == STRETCH),
    .q     (stretch_cnt)
  );

  // Only the asynchronous reset clears the abort count.
  rapcore_sat_counter #(.WIDTH(RST_CNT_WIDTH)) u_restart_cnt (
    .clk   (CLK),
    .rst_n (resetn_in),
    .clr   (1'b0),
    .en    (abort),
    .q     (restart_cnt_o)
  );

  always_ff @(posedge CLK or negedge resetn_in) begin
    if (!resetn_in) begin
      state          <= IDLE;
      domain_q       <= '0;
      all_released_q <= 1'b0;
      idx            <= '0;
      gap            <= '0;
    end else if (!go) begin
      state          <= IDLE;
      domain_q       <= '0;
      all_released_q <= 1'b0;
      idx            <= '0;
      gap            <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= STRETCH;
        end
        STRETCH: begin
          if (stretch_cnt == '1) begin
            domain_q[0] <= 1'b1;
            gap         <= '0;
            idx         <= IDX_W'(1);
            if (NUM_DOMAINS == 1) begin
              state          <= RUN;
              all_released_q <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (gap == GAP_W'(GAP_CYCLES - 1)) begin
            domain_q <= domain_q | (NUM_DOMAINS'(1) << idx);
            gap      <= '0;
            idx      <= idx + IDX_W'(1);
            if (idx == IDX_W'(NUM_DOMAINS - 1)) begin
              state          <= RUN;
              all_released_q <= 1'b1;
            end
          end else begin
            gap <= gap + GAP_W'(1);
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign domain_resetn_o = domain_q;
  assign all_released_o  = all_released_q;
  assign state_o         = state;
  assign mon_o           = stretch_cnt[CNT_WIDTH-1 -: MON_WIDTH];

endmodule

// File: tb/tb_rapcore_reset_sequencer.sv
// Self-checking bench: two sequencer configurations share one stimulus stream and
// are compared every cycle against an edge-count model, plus literal spot checks.
module tb_rapcore_reset_sequencer;

  localparam int CW  = 4;
  localparam int MW  = 2;
  localparam int L   = 1 << CW;
  localparam int ND0 = 3;
  localparam int GP0 = 3;
  localparam int RW0 = 2;
  localparam int ND1 = 1;
  localparam int GP1 = 5;
  localparam int RW1 = 8;

  logic           CLK = 1'b0;
  logic           resetn_in;
  logic           sys_rst_i;
  logic           run_req_i;

  logic [ND0-1:0] dom0;
  logic           all0;
  logic [1:0]     st0;
  logic [MW-1:0]  mon0;
  logic [RW0-1:0] rc0;

  logic [ND1-1:0] dom1;
  logic           all1;
  logic [1:0]     st1;
  logic [MW-1:0]  mon1;
  logic [RW1-1:0] rc1;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  rapcore_reset_sequencer #(
    .CNT_WIDTH(CW), .NUM_DOMAINS(ND0), .GAP_CYCLES(GP0),
    .MON_WIDTH(MW), .RST_CNT_WIDTH(RW0)
  ) dut0 (
    .CLK             (CLK),
    .resetn_in       (resetn_in),
    .sys_rst_i       (sys_rst_i),
    .run_req_i       (run_req_i),
    .domain_resetn_o (dom0),
    .all_released_o  (all0),
    .state_o         (st0),
    .mon_o           (mon0),
    .restart_cnt_o   (rc0)
  );

  rapcore_reset_sequencer #(
    .CNT_WIDTH(CW), .NUM_DOMAINS(ND1), .GAP_CYCLES(GP1),
    .MON_WIDTH(MW), .RST_CNT_WIDTH(RW1)
  ) dut1 (
    .CLK             (CLK),
    .resetn_in       (resetn_in),
    .sys_rst_i       (sys_rst_i),
    .run_req_i       (run_req_i),
    .domain_resetn_o (dom1),
    .all_released_o  (all1),
    .state_o         (st1),
    .mon_o           (mon1),
    .restart_cnt_o   (rc1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: "active" means a sequence is in progress; k counts edges since the
  // edge that started it. Everything observable follows from k alone.
  bit active = 1'b0;
  int k      = 0;
  int aborts = 0;

  always @(posedge CLK or negedge resetn_in) begin
    if (!resetn_in) begin
      active = 1'b0;
      k      = 0;
      aborts = 0;
    end else if (!(run_req_i && !sys_rst_i)) begin
      if (active) aborts++;
      active = 1'b0;
      k      = 0;
    end else if (!active) begin
      active = 1'b1;
      k      = 0;
    end else begin
      k++;
    end
  end

  function automatic int n_released(input int nd, input int gap);
    int n;
    if (!active || k < L) return 0;
    n = 1 + (k - L) / gap;
    return (n > nd) ? nd : n;
  endfunction

  function automatic int exp_state(input int nd, input int gap);
    int n;
    n = n_released(nd, gap);
    if (!active) return 0;
    if (n == 0)  return 1;
    if (n < nd)  return 2;
    return 3;
  endfunction

  function automatic int exp_mon();
    int c;
    if (!active) return 0;
    c = (k > L - 1) ? L - 1 : k;
    return c >> (CW - MW);
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("dom0",  32'(dom0), 32'((1 << n_released(ND0, GP0)) - 1));
      check("all0",  32'(all0), 32'(n_released(ND0, GP0) == ND0));
      check("st0",   32'(st0),  32'(exp_state(ND0, GP0)));
      check("mon0",  32'(mon0), 32'(exp_mon()));
      check("rc0",   32'(rc0),  32'(sat(aborts, RW0)));
      check("dom1",  32'(dom1), 32'((1 << n_released(ND1, GP1)) - 1));
      check("all1",  32'(all1), 32'(n_released(ND1, GP1) == ND1));
      check("st1",   32'(st1),  32'(exp_state(ND1, GP1)));
      check("mon1",  32'(mon1), 32'(exp_mon()));
      check("rc1",   32'(rc1),  32'(sat(aborts, RW1)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    resetn_in = 1'b0;
    sys_rst_i = 1'b0;
    run_req_i = 1'b0;
    step(3);
    check("rst_dom0", 32'(dom0), 32'd0);
    check("rst_st0",  32'(st0),  32'd0);
    check("rst_all0", 32'(all0), 32'd0);
    check("rst_rc0",  32'(rc0),  32'd0);
    resetn_in = 1'b1;
    cmp_en    = 1'b1;
    step(2);

    // Full bring-up; the next rising edge is edge 0.
    run_req_i = 1'b1;
    step(4);
    check("t1_mon_e3", 32'(mon0), 32'd0);
    step(1);
    check("t1_mon_e4", 32'(mon0), 32'd1);
    step(11);
    check("t1_dom_e15", 32'(dom0), 32'b000);
    check("t1_st_e15",  32'(st0),  32'd1);
    check("t1_mon_e15", 32'(mon0), 32'd3);
    check("t6_st_e15",  32'(st1),  32'd1);
    step(1);
    check("t1_dom_e16", 32'(dom0), 32'b001);
    check("t1_st_e16",  32'(st0),  32'd2);
    check("t6_dom_e16", 32'(dom1), 32'b1);
    check("t6_all_e16", 32'(all1), 32'd1);
    check("t6_st_e16",  32'(st1),  32'd3);
    step(3);
    check("t1_dom_e19", 32'(dom0), 32'b011);
    step(2);
    check("t1_all_e21", 32'(all0), 32'd0);
    step(1);
    check("t1_dom_e22", 32'(dom0), 32'b111);
    check("t1_all_e22", 32'(all0), 32'd1);
    check("t1_st_e22",  32'(st0),  32'd3);
    check("t1_mon_e22", 32'(mon0), 32'd3);
    run_req_i = 1'b0;
    step(1);
    check("t1_abort_dom", 32'(dom0), 32'd0);
    check("t1_abort_rc",  32'(rc0),  32'd1);
    check("t1_abort_mon", 32'(mon0), 32'd0);
    step(2);
    check("idle_no_count", 32'(rc0), 32'd1);

    // Abort with only domain 0 released, then a fresh full stretch.
    run_req_i = 1'b1;
    step(19);
    check("t2_dom_e18", 32'(dom0), 32'b001);
    run_req_i = 1'b0;
    step(1);
    check("t2_dom_e19", 32'(dom0), 32'b000);
    check("t2_st_e19",  32'(st0),  32'd0);
    check("t2_rc_e19",  32'(rc0),  32'd2);
    step(5);
    run_req_i = 1'b1;
    step(16);
    check("t2_dom_re15", 32'(dom0), 32'b000);
    step(1);
    check("t2_dom_re16", 32'(dom0), 32'b001);
    step(10);

    // One-cycle sys_rst_i in RUN; run_req_i stays high so it restarts.
    check("t3_pre_st", 32'(st0), 32'd3);
    sys_rst_i = 1'b1;
    step(1);
    sys_rst_i = 1'b0;
    check("t3_dom", 32'(dom0), 32'd0);
    check("t3_st",  32'(st0),  32'd0);
    check("t3_rc0", 32'(rc0),  32'd3);
    check("t3_rc1", 32'(rc1),  32'd3);
    step(22);
    check("t3_dom_e21", 32'(dom0), 32'b011);
    step(1);
    check("t3_dom_e22", 32'(dom0), 32'b111);
    check("t3_st_e22",  32'(st0),  32'd3);

    // Asynchronous reset mid-RELEASE, between clock edges.
    run_req_i = 1'b0;
    step(1);
    check("t4_rc0_sat", 32'(rc0), 32'd3);
    check("t4_rc1",     32'(rc1), 32'd4);
    run_req_i = 1'b1;
    step(18);
    check("t4_pre_st", 32'(st0), 32'd2);
    #2 resetn_in = 1'b0;
    #1;
    check("t4_dom0", 32'(dom0), 32'd0);
    check("t4_st0",  32'(st0),  32'd0);
    check("t4_all0", 32'(all0), 32'd0);
    check("t4_mon0", 32'(mon0), 32'd0);
    check("t4_rc0",  32'(rc0),  32'd0);
    check("t4_dom1", 32'(dom1), 32'd0);
    check("t4_rc1",  32'(rc1),  32'd0);
    run_req_i = 1'b0;
    @(negedge CLK);
    resetn_in = 1'b1;
    step(1);

    // Restart counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      run_req_i = 1'b1;
      step(3);
      run_req_i = 1'b0;
      step(1);
      check("t5_rc0", 32'(rc0), 32'(sat(i + 1, RW0)));
      check("t5_rc1", 32'(rc1), 32'(i + 1));
    end

    // Randomized phase, checked by the per-cycle comparator.
    for (int s = 0; s < 150; s++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0) begin
        #2 resetn_in = 1'b0;
        #1;
        check("rnd_async_dom0", 32'(dom0), 32'd0);
        check("rnd_async_rc0",  32'(rc0),  32'd0);
        @(negedge CLK);
        resetn_in = 1'b1;
      end else if (r == 1) begin
        sys_rst_i = 1'b1;
        step(1);
        sys_rst_i = 1'b0;
      end else begin
        run_req_i = ($urandom_range(0, 3) != 0);
        step(run_req_i ? $urandom_range(1, 40) : $urandom_range(1, 4));
      end
    end
    step(2);
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
